cacheline_adaptor: RTL and testbench

Bridges the cache's full-line interface to the burst-oriented physical memory port.
- Line side: the cache controller, which moves whole lines into and out of the per-set data arrays.
- Burst side: main memory / arbiter.
- Fills: a memory burst is assembled into one line.
- Writebacks: one line is split into a memory burst.

---
 rtl/cacheline_adaptor.sv | 115 +++++++++++
 tb/tb_cacheline_adaptor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor: assembles fills from s_burst beats and splits writebacks into beats.
// Define CACHELINE_ADAPTOR_PERF_EN to add completed fill / writeback counters.
module cacheline_adaptor #(
   parameter int s_offset = 5,
   parameter int s_burst  = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [8*(2**s_offset)-1:0] line_i,
   output logic [8*(2**s_offset)-1:0] line_o,
   input  logic [31:0]                address_i,
   input  logic                       read_i,
   input  logic                       write_i,
   output logic                       resp_o,
   input  logic [s_burst-1:0]         burst_i,
   output logic [s_burst-1:0]         burst_o,
   output logic [31:0]                address_o,
   output logic                       read_o,
   output logic                       write_o,
   input  logic                       resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
   ,
   output logic [31:0]                fill_count_o,
   output logic [31:0]                wb_count_o
`endif
);

   localparam int LINE_W = 8 * (2**s_offset);
   localparam int BEATS  = LINE_W / s_burst;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [31:0]      ADDR_MASK = ~32'((1 << s_offset) - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                          state, state_n;
   logic [CNT_W-1:0]                beat_cnt;
   logic [BEATS-1:0][s_burst-1:0]   line_buf;
   logic [BEATS-1:0][s_burst-1:0]   fill_line;
   logic                            last_beat;

   assign last_beat = resp_i && (beat_cnt == LAST_BEAT);

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state;
      case (state)
         IDLE:        if (write_i)        state_n = WRITE;
                      else if (read_i)    state_n = READ;
         READ, WRITE: if (last_beat)      state_n = DONE;
         DONE:                            state_n = IDLE;
         default:                         state_n = IDLE;
      endcase
   end

   // Line with the current beat merged in; becomes line_o on the last beat of a fill.
   always_comb begin
      fill_line           = line_buf;
      fill_line[beat_cnt] = burst_i;
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: line_buf is reset (not just the control flops) so burst_o reads 0 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt  <= '0;
         line_buf  <= '0;
         line_o    <= '0;
         address_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i || read_i) begin
                  address_o <= address_i & ADDR_MASK;
                  beat_cnt  <= '0;
                  if (write_i) line_buf <= line_i;
               end
            end
            READ, WRITE: begin
               if (resp_i) begin
                  beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                  if (state == READ) begin
                     line_buf <= fill_line;
                     if (last_beat) line_o <= fill_line;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign read_o  = (state == READ);
   assign write_o = (state == WRITE);
   assign resp_o  = (state == DONE);
   assign burst_o = line_buf[beat_cnt];

`ifdef CACHELINE_ADAPTOR_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_count_o <= '0;
         wb_count_o   <= '0;
      end else if (state_n == DONE) begin
         if (state == READ)  fill_count_o <= fill_count_o + 32'd1;
         if (state == WRITE) wb_count_o   <= wb_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor against a transaction-level model.
// Counter checks are active when CACHELINE_ADAPTOR_PERF_EN is defined.
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_EN
   logic [31:0]  fill_count_o, wb_count_o;
`endif

   cacheline_adaptor dut (
      .clk(clk), .rst(rst),
      .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
      , .fill_count_o(fill_count_o), .wb_count_o(wb_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: last completed fill line and completion counts since reset.
   logic [255:0] exp_line;
   logic [31:0]  exp_fills, exp_wbs;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   task automatic check_perf(input string tag);
`ifdef CACHELINE_ADAPTOR_PERF_EN
      check({tag, "_fill_count"}, fill_count_o, exp_fills);
      check({tag, "_wb_count"}, wb_count_o, exp_wbs);
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_line_o"}, line_o, 0);
      check({tag, "_burst_o"}, burst_o, 0);
      check({tag, "_address_o"}, address_o, 0);
      check({tag, "_read_o"}, read_o, 0);
      check({tag, "_write_o"}, write_o, 0);
      check({tag, "_resp_o"}, resp_o, 0);
      check_perf(tag);
   endtask

   task automatic drive_quiet();
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = 1'b0;
   endtask

   // Called at a falling edge: asserts rst mid-cycle, checks outputs before any rising edge.
   task automatic async_reset();
      #2 rst = 1'b1;
      exp_line  = '0;
      exp_fills = '0;
      exp_wbs   = '0;
      #1 check_zero("rst_async");
      drive_quiet();
      step();
      check_zero("rst_held");
      step();
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("idle_read_o", read_o, 0);
         check("idle_write_o", write_o, 0);
         check("idle_resp_o", resp_o, 0);
         read_i  = 1'b0;
         write_i = 1'b0;
         resp_i  = 1'($urandom_range(0, 1));
         burst_i = {$urandom, $urandom};
      end
   endtask

   // Fill: memory returns mem_line beat 0 (LSBs) first; line_o must equal mem_line afterwards.
   task automatic fill(input logic [31:0] addr, input logic [255:0] mem_line, input bit gaps);
      logic [31:0] aligned;
      int beat, cyc;
      aligned = {addr[31:5], 5'b0};
      beat = 0;
      cyc  = 0;
      step();
      check("fill_pre_read_o", read_o, 0);
      read_i    = 1'b1;
      write_i   = 1'b0;
      address_i = addr;
      resp_i    = 1'($urandom_range(0, 1));
      burst_i   = {$urandom, $urandom};
      while (beat < 4 && cyc < 64) begin
         step();
         cyc++;
         check("fill_read_o", read_o, 1);
         check("fill_write_o", write_o, 0);
         check("fill_resp_o_busy", resp_o, 0);
         check("fill_address_o", address_o, aligned);
         read_i    = 1'($urandom_range(0, 1));
         write_i   = 1'($urandom_range(0, 1));
         address_i = $urandom;
         line_i    = rand_line();
         if (gaps && $urandom_range(0, 2) == 0) begin
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
         end else begin
            resp_i  = 1'b1;
            burst_i = mem_line[64*beat +: 64];
            beat++;
         end
      end
      step();
      cyc++;
      drive_quiet();
      while (resp_o !== 1'b1 && cyc < 70) begin
         step();
         cyc++;
      end
      exp_line = mem_line;
      exp_fills++;
      check("fill_resp_o", resp_o, 1);
      check("fill_done_read_o", read_o, 0);
      check("fill_line_o", line_o, exp_line);
      if (!gaps) check("fill_latency", cyc, 5);
      check_perf("fill");
      step();
      check("fill_resp_pulse", resp_o, 0);
      check("fill_line_hold", line_o, exp_line);
      check("fill_after_read_o", read_o, 0);
   endtask

   // Writeback: strobe k taken from pat[k] for k < pat_len, random afterwards.
   task automatic wback(input logic [31:0] addr, input logic [255:0] wline, input bit conflict,
                        input logic [15:0] pat, input int pat_len);
      logic [31:0] aligned;
      int beat, cyc;
      bit strobe;
      aligned = {addr[31:5], 5'b0};
      beat = 0;
      cyc  = 0;
      step();
      check("wb_pre_write_o", write_o, 0);
      write_i   = 1'b1;
      read_i    = conflict;
      address_i = addr;
      line_i    = wline;
      while (beat < 4 && cyc < 64) begin
         step();
         check("wb_write_o", write_o, 1);
         check("wb_read_o", read_o, 0);
         check("wb_resp_o_busy", resp_o, 0);
         check("wb_address_o", address_o, aligned);
         check($sformatf("wb_burst_o_beat%0d", beat), burst_o, wline[64*beat +: 64]);
         write_i   = 1'($urandom_range(0, 1));
         read_i    = 1'($urandom_range(0, 1));
         address_i = $urandom;
         line_i    = rand_line();
         burst_i   = {$urandom, $urandom};
         strobe    = (cyc < pat_len) ? pat[cyc] : 1'($urandom_range(0, 1));
         resp_i    = strobe;
         if (strobe) beat++;
         cyc++;
      end
      step();
      cyc++;
      drive_quiet();
      while (resp_o !== 1'b1 && cyc < 70) begin
         step();
         cyc++;
      end
      exp_wbs++;
      check("wb_resp_o", resp_o, 1);
      check("wb_done_write_o", write_o, 0);
      check("wb_done_read_o", read_o, 0);
      check("wb_line_o_untouched", line_o, exp_line);
      check_perf("wb");
      step();
      check("wb_resp_pulse", resp_o, 0);
      check("wb_after_write_o", write_o, 0);
   endtask

   // read_i held high across three fills with resp_i always high: pulses 6 cycles apart.
   task automatic back_to_back();
      logic [63:0]  bursts [19];
      logic [255:0] l;
      int pulses [$];
      bit prev_pulse;
      prev_pulse = 1'b0;
      for (int c = 0; c < 19; c++) bursts[c] = {$urandom, $urandom};
      step();
      read_i    = 1'b1;
      write_i   = 1'b0;
      resp_i    = 1'b1;
      address_i = $urandom;
      burst_i   = bursts[0];
      for (int c = 1; c < 19; c++) begin
         step();
         if (prev_pulse) check("b2b_idle_read_o", read_o, 0);
         prev_pulse = (resp_o === 1'b1);
         if (resp_o === 1'b1) begin
            pulses.push_back(c);
            if (c >= 4) begin
               for (int k = 0; k < 4; k++) l[64*k +: 64] = bursts[c-4+k];
               check("b2b_line_o", line_o, l);
            end else begin
               check("b2b_early_pulse", c, 5);
            end
         end
         if (c < 18) burst_i = bursts[c];
         else begin
            read_i = 1'b0;
            resp_i = 1'b0;
         end
      end
      check("b2b_pulse_count", pulses.size(), 3);
      if (pulses.size() >= 2) begin
         check("b2b_first_pulse", pulses[0], 5);
         check("b2b_spacing", pulses[1] - pulses[0], 6);
      end
      exp_fills += 3;
      if (pulses.size() > 0) exp_line = l;
      check_perf("b2b");
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: bench did not finish within 500us");
      $fatal(1);
   end

   initial begin
      logic [255:0] d;
      rst       = 1'b1;
      line_i    = '0;
      address_i = '0;
      burst_i   = '0;
      drive_quiet();
      exp_line  = '0;
      exp_fills = '0;
      exp_wbs   = '0;
      step();
      step();
      check_zero("rst_init");
      rst = 1'b0;
      idle(2);

      fill(32'h0000_1234, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 1'b0);
      check("fill_fixed_line", line_o,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

      d = rand_line();
      wback(32'hDEAD_BEEF, d, 1'b0, 16'b1011001, 7);
      wback($urandom, rand_line(), 1'b1, 16'h000F, 4);

      idle(1);
      async_reset();

      step();
      read_i    = 1'b1;
      address_i = 32'h0000_8040;
      step();
      read_i  = 1'b0;
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
      burst_i = {$urandom, $urandom};
      step();
      check("midrst_read_o_before", read_o, 1);
      async_reset();
      idle(4);
      fill($urandom, rand_line(), 1'b0);

      idle(1);
      back_to_back();

      for (int t = 0; t < 24; t++) begin
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) fill($urandom, rand_line(), 1'b1);
         else wback($urandom, rand_line(), 1'($urandom_range(0, 1)), 16'h0000, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
